axi_rd_arbiter: RTL and testbench

- Two-master to one-slave AXI read-channel arbiter.
- Sits directly upstream of the AXI memory slave and feeds its AR channel and consumes its R channel.
- Master 0 is IFU instruction fetch; master 1 is LSU load.
- One outstanding transaction at a time; the granted master's address is buffered; round-robin arbitration; sticky watchdog flag for hung transactions.

---
 rtl/axi_rd_arbiter_pkg.sv | 15 +
 rtl/axi_rr_grant2.sv | 21 ++
 rtl/axi_rd_arbiter.sv | 113 +++++++++++
 tb/tb_axi_rd_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic [3:0] ID_IFU     = 4'd0;
  localparam logic [3:0] ID_LSU     = 4'd1;
  localparam int         DEF_ADDR_W = 64;
  localparam int         DEF_DATA_W = 64;

endpackage

// File: rtl/axi_rr_grant2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// master that did not win last time.
module axi_rr_grant2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt,
  output logic       any
);

  always_comb begin
    any = |req;
    gnt = 1'b0;
    unique case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI read arbiter, one transaction in flight,
// round-robin grant, sticky watchdog on hung transactions.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int         ADDR_W     = DEF_ADDR_W,
  parameter int         DATA_W     = DEF_DATA_W,
  parameter logic [3:0] ID0        = ID_IFU,
  parameter logic [3:0] ID1        = ID_LSU,
  parameter int         WAIT_LIMIT = 256
) (
  input  logic              clock,
  input  logic              reset,
  // IFU
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  // LSU
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  // slave
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic              timeout
);

  localparam int              CNT_W  = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIM    = CNT_W'(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(WAIT_LIMIT - 1);

  arb_state_t       state;
  logic             last_grant;
  logic             gnt_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             pick;
  logic             pick_any;
  logic             take;
  logic             in_data;
  logic             g_rready;

  axi_rr_grant2 u_rr (
    .req        ({m1_arvalid, m0_arvalid}),
    .last_grant (last_grant),
    .gnt        (pick),
    .any        (pick_any)
  );

  // Handshake-side outputs are combinational; gating with reset keeps them
  // quiet during the reset cycle even though state updates on the edge.
  assign take       = !reset && (state == IDLE) && pick_any;
  assign m0_arready = take && !pick;
  assign m1_arready = take &&  pick;

  assign in_data    = !reset && (state == DATA);
  assign g_rready   = gnt_q ? m1_rready : m0_rready;
  assign rready     = in_data && g_rready;
  assign m0_rvalid  = in_data && !gnt_q && rvalid;
  assign m1_rvalid  = in_data &&  gnt_q && rvalid;
  assign m0_rdata   = rdata;
  assign m1_rdata   = rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      araddr     <= '0;
      arid       <= '0;
      arvalid    <= 1'b0;
      wait_cnt   <= '0;
      timeout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (pick_any) begin
          gnt_q    <= pick;
          araddr   <= pick ? m1_araddr : m0_araddr;
          arid     <= pick ? ID1 : ID0;
          arvalid  <= 1'b1;
          wait_cnt <= '0;
          state    <= ADDR;
        end
        ADDR: if (arready) begin
          arvalid <= 1'b0;
          state   <= DATA;
        end
        DATA: if (rvalid && g_rready) begin
          last_grant <= gnt_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Watchdog only observes; the FSM keeps waiting after it fires.
      if (state != IDLE) begin
        if (wait_cnt != LIM)    wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == LIM_M1) timeout  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter with a behavioural 2-cycle-AR slave.
module tb_axi_rd_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [AW-1:0] m0_araddr;
  logic [DW-1:0] m0_rdata;
  logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [AW-1:0] m1_araddr;
  logic [DW-1:0] m1_rdata;
  logic [3:0]    arid;
  logic [AW-1:0] araddr;
  logic          arvalid, arready, rvalid, rready, timeout;
  logic [DW-1:0] rdata;

  typedef struct {
    logic          m;
    logic [3:0]    id;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m0_left = 0;
  int   m1_left = 0;
  logic mon_en = 1'b0;
  logic stall  = 1'b0;

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID0(4'd0), .ID1(4'd1), .WAIT_LIMIT(16)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .timeout(timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0013;
    return {~a[31:0], a[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave: arready the cycle after arvalid, data the cycle after AR handshake.
  always @(posedge clock) begin
    if (reset) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      arready <= arvalid && !arready && !stall;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= mem(araddr);
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // Masters drop arvalid after their last accepted request.
  always @(negedge clock) if (m0_arvalid && m0_arready) begin
    @(posedge clock); #1;
    if (m0_left > 0) m0_left--;
    if (m0_left == 0) m0_arvalid = 1'b0;
  end
  always @(negedge clock) if (m1_arvalid && m1_arready) begin
    @(posedge clock); #1;
    if (m1_left > 0) m1_left--;
    if (m1_left == 0) m1_arvalid = 1'b0;
  end

  // Scoreboard monitor.
  always @(negedge clock) if (mon_en) begin
    if (m0_arready || m1_arready) begin
      if (exp_q.size() == 0) chk("grant_unexpected", 1, 0);
      else chk("grant_master", m1_arready, exp_q[0].m);
    end
    if (arvalid && arready && exp_q.size() != 0) begin
      chk("arid", arid, exp_q[0].id);
      chk("araddr", araddr, exp_q[0].a);
    end
    if (m0_rvalid || m1_rvalid) chk("rvalid_excl", m0_rvalid & m1_rvalid, 0);
    if ((m0_rvalid && m0_rready) || (m1_rvalid && m1_rready)) begin
      if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
      else begin
        chk("resp_master", m1_rvalid, exp_q[0].m);
        chk("resp_data", m1_rvalid ? m1_rdata : m0_rdata, exp_q[0].d);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic m, input logic [AW-1:0] a);
    exp_t e;
    e.m = m; e.id = m ? 4'd1 : 4'd0; e.a = a; e.d = mem(a);
    exp_q.push_back(e);
  endtask

  task automatic drv(input int m, input logic [AW-1:0] a, input int n);
    if (m == 0) begin m0_left = n; m0_araddr = a; m0_arvalid = 1'b1; end
    else        begin m1_left = n; m1_araddr = a; m1_arvalid = 1'b1; end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clock);
    chk(tag, exp_q.size(), 0);
    @(posedge clock);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    mon_en = 1'b0; reset = 1'b1; stall = 1'b0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_left = 0; m1_left = 0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] held;
    reset = 1'b1;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_araddr = '0; m1_araddr = '0;
    m0_rready = 1'b1; m1_rready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arid", arid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // 1: single IFU fetch
    push(1'b0, 64'h8000_0000);
    drv(0, 64'h8000_0000, 1);
    @(negedge clock);
    chk("t1_arready", m0_arready, 1);
    @(negedge clock);
    chk("t1_arready_pulse", m0_arready, 0);
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 64'h8000_0000);
    drain("t1_drain");

    // 2: simultaneous requests after reset, m0 first
    do_reset();
    push(1'b0, 64'h8000_0000);
    push(1'b1, 64'h8000_0008);
    drv(0, 64'h8000_0000, 1);
    drv(1, 64'h8000_0008, 1);
    drain("t2_drain");

    // 3: continuous contention alternates 0,1,0,1
    @(posedge clock); #1;
    push(1'b0, 64'h8000_0100);
    push(1'b1, 64'h8000_0200);
    push(1'b0, 64'h8000_0100);
    push(1'b1, 64'h8000_0200);
    drv(0, 64'h8000_0100, 2);
    drv(1, 64'h8000_0200, 2);
    drain("t3_drain");

    // 4: m1 data stall for 5 cycles
    @(posedge clock); #1;
    m1_rready = 1'b0;
    push(1'b1, 64'h8000_0300);
    drv(1, 64'h8000_0300, 1);
    for (int i = 0; i < 40 && !m1_rvalid; i++) @(negedge clock);
    chk("t4_rvalid_seen", m1_rvalid, 1);
    held = m1_rdata;
    for (int k = 0; k < 5; k++) begin
      chk("t4_stall_rvalid", m1_rvalid, 1);
      chk("t4_stall_rdata", m1_rdata, mem(64'h8000_0300));
      chk("t4_stall_stable", m1_rdata, held);
      chk("t4_no_arvalid", arvalid, 0);
      @(negedge clock);
    end
    @(posedge clock); #1;
    m1_rready = 1'b1;
    @(negedge clock);
    chk("t4_hs_rready", rready, 1);
    @(negedge clock);
    chk("t4_done", m1_rvalid, 0);
    chk("t4_queue", exp_q.size(), 0);

    // 5: slave never accepts -> watchdog after 16 ADDR cycles
    @(posedge clock); #1;
    stall = 1'b1;
    push(1'b0, 64'h8000_0400);
    drv(0, 64'h8000_0400, 1);
    @(negedge clock);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      chk("t5_arvalid", arvalid, 1);
      chk("t5_araddr", araddr, 64'h8000_0400);
      chk("t5_timeout", timeout, (k >= 17) ? 1 : 0);
    end
    do_reset();
    @(negedge clock);
    chk("t5_timeout_cleared", timeout, 0);

    // 6: reset while in DATA, then m0 wins the first tie
    @(posedge clock); #1;
    m0_rready = 1'b0;
    push(1'b0, 64'h8000_0500);
    drv(0, 64'h8000_0500, 1);
    for (int i = 0; i < 40 && !m0_rvalid; i++) @(negedge clock);
    chk("t6_in_data", m0_rvalid, 1);
    @(posedge clock); #1;
    mon_en = 1'b0; reset = 1'b1; m0_rready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("t6_arvalid", arvalid, 0);
    chk("t6_rready", rready, 0);
    chk("t6_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("t6_arready", {m0_arready, m1_arready}, 0);
    chk("t6_araddr", araddr, 0);
    chk("t6_timeout", timeout, 0);
    mon_en = 1'b1;
    @(posedge clock); #1;
    push(1'b0, 64'h8000_0600);
    push(1'b1, 64'h8000_0608);
    drv(0, 64'h8000_0600, 1);
    drv(1, 64'h8000_0608, 1);
    drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
